// File: rtl/rx_block_lock.sv
// 64b/66b receive block lock, slip control and hi-BER monitor between the RX gearbox and the PCS decoder.
// Data and headers pass through one register stage, and their valids are masked by the current lock state.
module rx_block_lock #(
    parameter int DATA_WIDTH    = 32,
    parameter int LOCK_COUNT    = 64,
    parameter int INVALID_LIMIT = 16,
    parameter int SLIP_WAIT     = 32,
    parameter int BER_WINDOW    = 1000,
    parameter int BER_LIMIT     = 16,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     xver_rx_clk,
    input  logic                     i_rx_reset,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic [1:0]               i_header,
    input  logic                     i_data_valid,
    input  logic                     i_header_valid,
    input  logic                     i_clear_count,
    output logic                     o_gearbox_slip,
    output logic                     o_block_lock,
    output logic                     o_hi_ber,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic [1:0]               o_header,
    output logic                     o_data_valid,
    output logic                     o_header_valid,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

    localparam int SH_W   = $clog2(LOCK_COUNT + 1);
    localparam int INV_W  = $clog2(INVALID_LIMIT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int BT_W   = $clog2(BER_WINDOW + 1);
    localparam int BC_W   = $clog2(BER_LIMIT + 1);

    localparam logic [SH_W-1:0]          SH_LAST   = SH_W'(LOCK_COUNT - 1);
    localparam logic [SH_W-1:0]          SH_ONE    = SH_W'(1);
    localparam logic [INV_W-1:0]         INV_LAST  = INV_W'(INVALID_LIMIT - 1);
    localparam logic [INV_W-1:0]         INV_ONE   = INV_W'(1);
    localparam logic [INV_W-1:0]         INV_ZERO  = INV_W'(0);
    localparam logic [WAIT_W-1:0]        WAIT_LAST = WAIT_W'(SLIP_WAIT - 2);
    localparam logic [WAIT_W-1:0]        WAIT_ONE  = WAIT_W'(1);
    localparam logic [BT_W-1:0]          BT_LAST   = BT_W'(BER_WINDOW - 1);
    localparam logic [BT_W-1:0]          BT_ONE    = BT_W'(1);
    localparam logic [BC_W-1:0]          BC_MAX    = BC_W'(BER_LIMIT);
    localparam logic [BC_W-1:0]          BC_ONE    = BC_W'(1);
    localparam logic [BC_W-1:0]          BC_ZERO   = BC_W'(0);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX   = {ERR_CNT_WIDTH{1'b1}};
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE   = ERR_CNT_WIDTH'(1);

    if ((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_width
        $error("rx_block_lock: DATA_WIDTH must be 32 or 64");
    end
    if (SLIP_WAIT < 2) begin : g_bad_wait
        $error("rx_block_lock: SLIP_WAIT must be at least 2");
    end

    typedef enum logic [1:0] {
        S_UNLOCK = 2'd0,
        S_SLIP   = 2'd1,
        S_WAIT   = 2'd2,
        S_LOCK   = 2'd3
    } state_t;

    // A sync header is legal when its two bits differ (01 or 10).
    function automatic logic header_ok(input logic [1:0] hdr);
        return hdr[1] ^ hdr[0];
    endfunction

    state_t              state_r, state_nxt_s;
    logic [SH_W-1:0]     sh_cnt_r, sh_cnt_nxt_s;
    logic [SH_W-1:0]     win_cnt_r, win_cnt_nxt_s;
    logic [INV_W-1:0]    inv_cnt_r, inv_cnt_nxt_s;
    logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
    logic [BT_W-1:0]     ber_timer_r;
    logic [BC_W-1:0]     ber_cnt_r;
    logic [BC_W-1:0]     ber_new_s;
    logic                hdr_ok_s, hdr_bad_s, lock_nxt_s;

    assign hdr_ok_s   = i_header_valid & header_ok(i_header);
    assign hdr_bad_s  = i_header_valid & ~header_ok(i_header);
    assign lock_nxt_s = (state_nxt_s == S_LOCK);
    assign ber_new_s  = hdr_bad_s ? BC_ONE : BC_ZERO;

    // Next-state logic for the lock FSM and its header/cycle counters.
    always_comb begin
        state_nxt_s    = state_r;
        sh_cnt_nxt_s   = sh_cnt_r;
        win_cnt_nxt_s  = win_cnt_r;
        inv_cnt_nxt_s  = inv_cnt_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            S_UNLOCK: begin
                if (hdr_ok_s) begin
                    if (sh_cnt_r == SH_LAST) begin
                        state_nxt_s  = S_LOCK;
                        sh_cnt_nxt_s = '0;
                    end else begin
                        sh_cnt_nxt_s = sh_cnt_r + SH_ONE;
                    end
                end else if (hdr_bad_s) begin
                    state_nxt_s  = S_SLIP;
                    sh_cnt_nxt_s = '0;
                end else begin
                    sh_cnt_nxt_s = sh_cnt_r;
                end
            end
            S_SLIP: begin
                state_nxt_s    = S_WAIT;
                wait_cnt_nxt_s = '0;
            end
            // The slip cycle is the first settle cycle, so slips repeat every SLIP_WAIT+1 cycles.
            S_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_nxt_s    = S_UNLOCK;
                    wait_cnt_nxt_s = '0;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
                end
            end
            S_LOCK: begin
                if (hdr_bad_s && (inv_cnt_r == INV_LAST)) begin
                    state_nxt_s   = S_SLIP;
                    win_cnt_nxt_s = '0;
                    inv_cnt_nxt_s = '0;
                end else if (i_header_valid && (win_cnt_r == SH_LAST)) begin
                    win_cnt_nxt_s = '0;
                    inv_cnt_nxt_s = '0;
                end else if (i_header_valid) begin
                    win_cnt_nxt_s = win_cnt_r + SH_ONE;
                    inv_cnt_nxt_s = inv_cnt_r + (hdr_bad_s ? INV_ONE : INV_ZERO);
                end else begin
                    win_cnt_nxt_s = win_cnt_r;
                end
            end
            default: begin
                state_nxt_s    = S_UNLOCK;
                sh_cnt_nxt_s   = '0;
                win_cnt_nxt_s  = '0;
                inv_cnt_nxt_s  = '0;
                wait_cnt_nxt_s = '0;
            end
        endcase
    end

    // FSM state, counters and the lock/slip outputs registered from the next state.
    always_ff @(posedge xver_rx_clk or posedge i_rx_reset) begin
        if (i_rx_reset) begin
            state_r        <= S_UNLOCK;
            sh_cnt_r       <= '0;
            win_cnt_r      <= '0;
            inv_cnt_r      <= '0;
            wait_cnt_r     <= '0;
            o_block_lock   <= 1'b0;
            o_gearbox_slip <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            sh_cnt_r       <= sh_cnt_nxt_s;
            win_cnt_r      <= win_cnt_nxt_s;
            inv_cnt_r      <= inv_cnt_nxt_s;
            wait_cnt_r     <= wait_cnt_nxt_s;
            o_block_lock   <= lock_nxt_s;
            o_gearbox_slip <= (state_nxt_s == S_SLIP);
        end
    end

    // Hi-BER window; a bad header on the wrap cycle opens the count of the new window.
    always_ff @(posedge xver_rx_clk or posedge i_rx_reset) begin
        if (i_rx_reset) begin
            ber_timer_r <= '0;
            ber_cnt_r   <= '0;
            o_hi_ber    <= 1'b0;
        end else if (!o_block_lock || !lock_nxt_s) begin
            ber_timer_r <= '0;
            ber_cnt_r   <= '0;
            o_hi_ber    <= 1'b0;
        end else if (ber_timer_r == BT_LAST) begin
            ber_timer_r <= '0;
            ber_cnt_r   <= ber_new_s;
            o_hi_ber    <= (ber_cnt_r == BC_MAX) || (ber_new_s == BC_MAX);
        end else begin
            ber_timer_r <= ber_timer_r + BT_ONE;
            if (hdr_bad_s && (ber_cnt_r != BC_MAX)) begin
                ber_cnt_r <= ber_cnt_r + BC_ONE;
                o_hi_ber  <= o_hi_ber | ((ber_cnt_r + BC_ONE) == BC_MAX);
            end else begin
                ber_cnt_r <= ber_cnt_r;
            end
        end
    end

    // Saturating count of bad headers seen while locked; clear wins over a concurrent increment.
    always_ff @(posedge xver_rx_clk or posedge i_rx_reset) begin
        if (i_rx_reset) begin
            o_err_count <= '0;
        end else if (i_clear_count) begin
            o_err_count <= '0;
        end else if (o_block_lock && hdr_bad_s && (o_err_count != ERR_MAX)) begin
            o_err_count <= o_err_count + ERR_ONE;
        end else begin
            o_err_count <= o_err_count;
        end
    end

    // One-cycle datapath stage with valids masked by the lock state at sample time.
    always_ff @(posedge xver_rx_clk or posedge i_rx_reset) begin
        if (i_rx_reset) begin
            o_data         <= '0;
            o_header       <= 2'b00;
            o_data_valid   <= 1'b0;
            o_header_valid <= 1'b0;
        end else begin
            o_data         <= i_data;
            o_header       <= i_header;
            o_data_valid   <= i_data_valid & o_block_lock;
            o_header_valid <= i_header_valid & o_block_lock;
        end
    end

endmodule

// File: tb/tb_rx_block_lock.sv
// Directed and randomized bench for rx_block_lock (DATA_WIDTH=64, ERR_CNT_WIDTH=4) against a
// cycle-level behavioural model of the lock, slip, hi-BER and error-count rules.
module tb_rx_block_lock;

    localparam int DW = 64;
    localparam int LC = 64;
    localparam int IL = 16;
    localparam int SW = 32;
    localparam int BW = 1000;
    localparam int BL = 16;
    localparam int EW = 4;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          i_rx_reset = 1'b1;
    logic [DW-1:0] i_data = '0;
    logic [1:0]    i_header = 2'b00;
    logic          i_data_valid = 1'b0;
    logic          i_header_valid = 1'b0;
    logic          i_clear_count = 1'b0;
    logic          o_gearbox_slip, o_block_lock, o_hi_ber;
    logic [DW-1:0] o_data;
    logic [1:0]    o_header;
    logic          o_data_valid, o_header_valid;
    logic [EW-1:0] o_err_count;

    rx_block_lock #(
        .DATA_WIDTH(DW), .LOCK_COUNT(LC), .INVALID_LIMIT(IL), .SLIP_WAIT(SW),
        .BER_WINDOW(BW), .BER_LIMIT(BL), .ERR_CNT_WIDTH(EW)
    ) dut (
        .xver_rx_clk(clk), .i_rx_reset(i_rx_reset), .i_data(i_data), .i_header(i_header),
        .i_data_valid(i_data_valid), .i_header_valid(i_header_valid), .i_clear_count(i_clear_count),
        .o_gearbox_slip(o_gearbox_slip), .o_block_lock(o_block_lock), .o_hi_ber(o_hi_ber),
        .o_data(o_data), .o_header(o_header), .o_data_valid(o_data_valid),
        .o_header_valid(o_header_valid), .o_err_count(o_err_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state, written in terms of header runs and windows rather than FSM states.
    bit          m_lock, m_slip, m_hi, m_dv, m_hv;
    int          m_err, m_run, m_ignore, m_win_hdr, m_win_bad, m_ber_t, m_ber_bad;
    logic [DW-1:0] m_data;
    logic [1:0]  m_hdr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_slip = 0; m_hi = 0; m_dv = 0; m_hv = 0;
        m_err = 0; m_run = 0; m_ignore = 0; m_win_hdr = 0; m_win_bad = 0;
        m_ber_t = 0; m_ber_bad = 0; m_data = '0; m_hdr = 2'b00;
    endtask

    task automatic model_edge();
        bit good, bad, was_lock, reached;
        good = i_header_valid && (i_header == 2'b01 || i_header == 2'b10);
        bad  = i_header_valid && !good;
        was_lock = m_lock;
        m_data = i_data;
        m_hdr  = i_header;
        m_dv   = i_data_valid & was_lock;
        m_hv   = i_header_valid & was_lock;
        if (i_clear_count) m_err = 0;
        else if (was_lock && bad && m_err < ERR_MAX) m_err++;
        m_slip = 0;
        if (was_lock) begin
            if (i_header_valid) begin
                m_win_hdr++;
                if (bad) m_win_bad++;
            end
            if (m_win_bad == IL) begin
                m_lock = 0; m_slip = 1; m_ignore = SW; m_win_hdr = 0; m_win_bad = 0;
            end else if (m_win_hdr == LC) begin
                m_win_hdr = 0; m_win_bad = 0;
            end
        end else if (m_ignore > 0) begin
            m_ignore--;
        end else if (good) begin
            m_run++;
            if (m_run == LC) begin m_lock = 1; m_run = 0; end
        end else if (bad) begin
            m_run = 0; m_slip = 1; m_ignore = SW;
        end
        if (was_lock && m_lock) begin
            if (m_ber_t == BW - 1) begin
                reached   = (m_ber_bad >= BL);
                m_ber_t   = 0;
                m_ber_bad = bad ? 1 : 0;
                m_hi      = reached || (m_ber_bad >= BL);
            end else begin
                m_ber_t++;
                if (bad && m_ber_bad < BL) m_ber_bad++;
                if (m_ber_bad >= BL) m_hi = 1;
            end
        end else begin
            m_ber_t = 0; m_ber_bad = 0; m_hi = 0;
        end
    endtask

    task automatic check_all();
        check("block_lock",   64'(o_block_lock),   64'(m_lock));
        check("gearbox_slip", 64'(o_gearbox_slip), 64'(m_slip));
        check("hi_ber",       64'(o_hi_ber),       64'(m_hi));
        check("err_count",    64'(o_err_count),    64'(m_err));
        check("data_valid",   64'(o_data_valid),   64'(m_dv));
        check("header_valid", 64'(o_header_valid), 64'(m_hv));
        check("data",         o_data,              m_data);
        check("header",       64'(o_header),       64'(m_hdr));
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic step(input bit hv, input logic [1:0] hdr, input bit clr);
        i_header_valid = hv;
        i_header       = hdr;
        i_clear_count  = clr;
        i_data_valid   = ($urandom_range(0, 3) != 0);
        i_data         = {$urandom(), $urandom()};
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        i_rx_reset = 1'b1;
        i_header_valid = 1'b0; i_data_valid = 1'b0; i_clear_count = 1'b0;
        i_header = 2'b00; i_data = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        i_rx_reset = 1'b0;
    endtask

    initial begin
        int slip_at[$];
        int n_slip;
        int last;
        int rate;
        int cnt;
        bit pos[LC];

        // 1: continuous 01 headers lock exactly on the 64th, no slip
        do_reset();
        n_slip = 0;
        for (int i = 1; i <= LC; i++) begin
            step(1'b1, 2'b01, 1'b0);
            if (o_gearbox_slip) n_slip++;
            if (i == LC - 1) check("no_lock_at_63", 64'(o_block_lock), 64'd0);
        end
        check("lock_at_64", 64'(o_block_lock), 64'd1);
        check("no_slip_t1", 64'(n_slip), 64'd0);

        // 2: 11 headers slip every SLIP_WAIT+1 cycles, then 10 headers relock
        do_reset();
        for (int i = 1; i <= 120; i++) begin
            step(1'b1, 2'b11, 1'b0);
            if (o_gearbox_slip) slip_at.push_back(i);
        end
        check("slip_count", 64'(slip_at.size()), 64'd4);
        check("first_slip", 64'(slip_at[0]), 64'd1);
        for (int k = 1; k < slip_at.size(); k++)
            check("slip_period", 64'(slip_at[k] - slip_at[k-1]), 64'(SW + 1));
        n_slip = 0;
        for (int i = 1; i <= 120; i++) begin
            step(1'b1, 2'b10, 1'b0);
            if (o_gearbox_slip) n_slip++;
        end
        check("no_slip_after_good", 64'(n_slip), 64'd0);
        check("relock_t2", 64'(o_block_lock), 64'd1);

        // 3: 15 invalid in a window keeps lock, the 16th drops it
        do_reset();
        for (int i = 1; i <= LC; i++) step(1'b1, good_hdr(), 1'b0);
        foreach (pos[j]) pos[j] = 1'b0;
        cnt = 0;
        while (cnt < IL - 1) begin
            rate = $urandom_range(0, LC - 1);
            if (!pos[rate]) begin pos[rate] = 1'b1; cnt++; end
        end
        for (int i = 0; i < LC; i++) step(1'b1, pos[i] ? bad_hdr() : good_hdr(), 1'b0);
        check("lock_15_invalid", 64'(o_block_lock), 64'd1);
        check("err_15", 64'(o_err_count), 64'd15);
        foreach (pos[j]) pos[j] = 1'b0;
        cnt = 0;
        last = 0;
        while (cnt < IL) begin
            rate = $urandom_range(0, LC - 1);
            if (!pos[rate]) begin
                pos[rate] = 1'b1; cnt++;
                if (rate > last) last = rate;
            end
        end
        for (int i = 0; i <= last; i++) step(1'b1, pos[i] ? bad_hdr() : good_hdr(), 1'b0);
        check("lock_lost_16", 64'(o_block_lock), 64'd0);
        check("slip_after_loss", 64'(o_gearbox_slip), 64'd1);
        step(1'b0, 2'b00, 1'b0);
        check("slip_one_cycle", 64'(o_gearbox_slip), 64'd0);

        // 4: 16 invalid spread one per 60 headers set hi_ber, a clean window clears it
        do_reset();
        for (int i = 1; i <= LC; i++) step(1'b1, good_hdr(), 1'b0);
        for (int j = 1; j <= 2 * BW + 5; j++) begin
            step(1'b1, (((j - 1) % 60 == 0) && (j <= 901)) ? bad_hdr() : good_hdr(), 1'b0);
            if (j == 841) check("hi_ber_before_16", 64'(o_hi_ber), 64'd0);
            if (j == 901) check("hi_ber_at_16", 64'(o_hi_ber), 64'd1);
            if (j == 1500) check("hi_ber_held", 64'(o_hi_ber), 64'd1);
            if (j == 1999) check("hi_ber_before_wrap", 64'(o_hi_ber), 64'd1);
            if (j == 2000) check("hi_ber_clear_wrap", 64'(o_hi_ber), 64'd0);
        end
        check("lock_through_ber", 64'(o_block_lock), 64'd1);

        // 5: error counter saturates, clear beats a concurrent invalid header
        do_reset();
        for (int i = 1; i <= LC; i++) step(1'b1, good_hdr(), 1'b0);
        for (int k = 0; k < 160; k++) step(1'b1, (k % 8 == 0) ? bad_hdr() : good_hdr(), 1'b0);
        check("err_saturated", 64'(o_err_count), 64'd15);
        step(1'b1, bad_hdr(), 1'b1);
        check("err_clear_priority", 64'(o_err_count), 64'd0);

        // 6: headers on alternate beats, then asynchronous reset mid-lock and relock
        do_reset();
        for (int i = 1; i <= 2 * LC + 20; i++) begin
            step(i % 2 == 0, good_hdr(), 1'b0);
            if (i == 2 * LC - 1) check("alt_no_lock_63", 64'(o_block_lock), 64'd0);
            if (i == 2 * LC) check("alt_lock_64", 64'(o_block_lock), 64'd1);
        end
        i_rx_reset = 1'b1;
        #1;
        check("async_lock", 64'(o_block_lock), 64'd0);
        check("async_dv", 64'(o_data_valid), 64'd0);
        check("async_data", o_data, 64'd0);
        check("async_hdr", 64'(o_header), 64'd0);
        model_reset();
        #1;
        i_rx_reset = 1'b0;
        for (int i = 1; i <= LC; i++) begin
            step(1'b1, good_hdr(), 1'b0);
            if (i == LC - 1) check("relock_not_63", 64'(o_block_lock), 64'd0);
        end
        check("relock_64", 64'(o_block_lock), 64'd1);

        // Randomized segments with varying invalid-header density
        for (int seg = 0; seg < 15; seg++) begin
            case ($urandom_range(0, 2))
                0:       rate = 100;
                1:       rate = 20;
                default: rate = 3;
            endcase
            for (int c = 0; c < 200; c++)
                step($urandom_range(0, 3) != 0,
                     ($urandom_range(1, rate) == 1) ? bad_hdr() : good_hdr(),
                     $urandom_range(0, 63) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
